dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop.
- WIDTH-bit, DEPTH-stage register pipeline, each stage a bank of D flip-flops with a per-stage valid bit.
- Ready/valid handshake on both ends; bubble-collapsing under backpressure; synchronous flush.
- Used as a retiming/delay element between producer and consumer blocks; the DUT wrapper exposes it through an interface in the same way as the plain DFF.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every stage data register on rst (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  producer has a word on din.
- in_ready  output  1  pipeline can accept din this cycle.
- din  input  WIDTH  input data.
- out_valid  output  1  dout holds a valid word (= valid bit of stage DEPTH-1).
- out_ready  input  1  consumer takes dout this cycle.
- dout  output  WIDTH  data of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages (registered state, not a separate counter).

Behaviour:
- Reset (rst=1 at a rising edge):
  - all valid bits = 0 and all data registers = RESET_VAL;
  - so out_valid=0, dout=RESET_VAL, count=0, in_ready=1.
  - rst overrides flush and any transfer in the same cycle.
- Stages are indexed 0 (input) to DEPTH-1 (output); v[i] is the valid bit and d[i] the data of stage i.
- Move condition, combinational:
  - go[DEPTH-1] = v[DEPTH-1] & out_ready.
  - go[i] = v[i] & (~v[i+1] | go[i+1]) for i < DEPTH-1.
- in_ready = ~v[0] | go[0]. This is combinational from out_ready through the valid chain; no registered skid.
- Input transfer: accept = in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- Per rising edge, when rst=0 and flush=0:
  - stage i>0 loads d[i-1]/v[i-1] if go[i-1];
  - otherwise, if go[i], it clears v[i];
  - otherwise it holds.
  - Stage 0 loads din with v[0]=1 if accept; otherwise, if go[0], it clears v[0]; otherwise it holds.
- Data registers load only when a valid word moves in. They are not cleared on drain or flush.
  - dout is meaningful only while out_valid=1.
  - After reset, with no traffic, dout = RESET_VAL.
- Bubble collapse: an empty stage is filled whenever its upstream neighbour is valid, even when out_ready=0. A stalled full pipeline therefore holds exactly DEPTH words.
- Latency: a word accepted in cycle t with no backpressure has out_valid=1 in cycle t+DEPTH. Throughput is 1 word/cycle.
- Ordering: strict FIFO. No word is duplicated, dropped or reordered except by flush or rst.
- Full pipeline with out_ready=1:
  - in_ready=1, so one accept and one output happen simultaneously;
  - count is unchanged.
- Full pipeline with out_ready=0: in_ready=0 and din is ignored.
- flush=1 (rst=0):
  - all v cleared at the edge; the in-flight words are discarded;
  - din is not accepted that cycle, even if in_valid & in_ready; the producer must not treat it as a transfer;
  - in_ready is still driven by the formula.
  - The output word presented during the flush cycle counts as transferred if out_ready=1.
- count:
  - count_next = count + accept - out_transfer;
  - count = 0 after flush/rst;
  - count never exceeds DEPTH.
- DEPTH=1 degenerates to a single-entry register slice: in_ready = ~v[0] | out_ready.
- Mid-operation reset behaves exactly like the power-on reset. No output changes before the edge, because reset is synchronous.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, din=8'hAA -> out_valid=0, count=0, dout=8'h00, in_ready=1; nothing emerges afterward.
- Streaming: DEPTH=4, out_ready=1, send 8'h01..8'h0A back-to-back -> 8'h01 at out_valid in the 4th cycle after its accept; then one word per cycle in order; count steady at 4.
- Backpressure: out_ready=0, offer 6 words -> first 4 accepted, in_ready=0 after the 4th, count=4. Release out_ready -> words 1..6 out in order, no gaps beyond the first 4-cycle latency.
- Bubble collapse: send words A, idle 2 cycles, B, with out_ready=0 -> A and B occupy stages 3 and 2 (count=2); on release, B follows A on consecutive cycles.
- Flush: 3 words in flight plus in_valid=1, din=8'h55 in the flush cycle -> count=0 next cycle, out_valid=0, 8'h55 never appears at dout.
- Random: 30 transactions with random in_valid/out_ready/din -> scoreboard shows in-order match and count always in 0..DEPTH. Repeat with DEPTH=1 and WIDTH=1.

Source files
------------

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with a per-stage valid bit,
// ready/valid handshake on both ends, bubble collapse and synchronous flush.
module dff_pipe #(
  parameter int unsigned            WIDTH     = 8,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [DEPTH-1:0] go_s;
  logic             accept_s;

  // Occupancy is the population count of the valid bits, so it cannot drift.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(vec[i]);
    end
    return acc;
  endfunction

  // Move chain: a stage advances when its downstream neighbour is empty or advancing.
  always_comb begin
    go_s = {DEPTH{1'b0}};
    go_s[DEPTH-1] = v_r[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      go_s[i] = v_r[i] & (~v_r[i+1] | go_s[i+1]);
    end
  end

  assign in_ready = ~v_r[0] | go_s[0];
  assign accept_s = in_valid & in_ready;

  // Stage registers: reset beats flush beats traffic; data only loads with a valid word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        d_r[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v_r <= {DEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        d_r[0] <= din;
        v_r[0] <= 1'b1;
      end else if (go_s[0]) begin
        v_r[0] <= 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (go_s[i-1]) begin
          d_r[i] <= d_r[i-1];
          v_r[i] <= 1'b1;
        end else if (go_s[i]) begin
          v_r[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = v_r[DEPTH-1];
  assign dout      = d_r[DEPTH-1];
  assign count     = popcount(v_r);

endmodule

// File: tb/tb_dff_pipe.sv
// Directed and scoreboarded checks of dff_pipe at WIDTH=8/DEPTH=4 and
// WIDTH=1/DEPTH=1.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] din, dout;
  logic [2:0] count;
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [0:0] s_din, s_dout, s_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .count(count)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_small (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .din(s_din),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout), .count(s_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic       sq[$];
    int         sent, got, s_sent, s_got;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; din = 8'hAA; out_ready = 1'b0;
    s_in_valid = 1'b0; s_din = 1'b0; s_out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_s_out_valid", 32'(s_out_valid), 32'd0);
    check_eq("rst_s_count", 32'(s_count), 32'd0);
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("rst_nothing_out", 32'(out_valid), 32'd0);
      next_cycle();
    end

    // Streaming: 10 words back-to-back, first out 4 cycles after accept.
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 10);
      din = 8'(c + 1);
      @(negedge clk);
      check_eq("str_in_ready", 32'(in_ready), 32'd1);
      if (c >= 4 && c < 14) begin
        check_eq("str_valid", 32'(out_valid), 32'd1);
        check_eq("str_dout", 32'(dout), 32'(c - 3));
      end else begin
        check_eq("str_idle", 32'(out_valid), 32'd0);
      end
      if (c >= 4 && c <= 10) check_eq("str_count", 32'(count), 32'd4);
      next_cycle();
    end

    // Backpressure: only 4 of 6 offered words fit, then drain with no gaps.
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      din = 8'h20 + 8'((c < 4) ? c + 1 : 5);
      @(negedge clk);
      check_eq("bp_in_ready", 32'(in_ready), (c < 4) ? 32'd1 : 32'd0);
      check_eq("bp_count", 32'(count), (c < 4) ? 32'(c) : 32'd4);
      next_cycle();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      in_valid = (r < 2);
      din = 8'h25 + 8'(r);
      @(negedge clk);
      check_eq("bp_rel_valid", 32'(out_valid), (r < 6) ? 32'd1 : 32'd0);
      if (r < 6) check_eq("bp_rel_dout", 32'(dout), 32'h21 + 32'(r));
      next_cycle();
    end

    // Bubble collapse: A, two idle cycles, B, all under backpressure.
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c == 0 || c == 3);
      din = (c == 0) ? 8'hA1 : 8'hB2;
      @(negedge clk);
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bub_count", 32'(count), 32'd2);
    check_eq("bub_valid_a", 32'(out_valid), 32'd1);
    check_eq("bub_dout_a", 32'(dout), 32'hA1);
    out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("bub_valid_b", 32'(out_valid), 32'd1);
    check_eq("bub_dout_b", 32'(dout), 32'hB2);
    next_cycle();
    @(negedge clk);
    check_eq("bub_empty", 32'(out_valid), 32'd0);
    check_eq("bub_count0", 32'(count), 32'd0);
    next_cycle();

    // Flush with three words in flight and 8'h55 offered in the flush cycle.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      din = 8'h31 + 8'(c);
      @(negedge clk);
      next_cycle();
    end
    flush = 1'b1; din = 8'h55;
    @(negedge clk);
    check_eq("fl_count_before", 32'(count), 32'd3);
    check_eq("fl_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("fl_out_valid", 32'(out_valid), 32'd0);
      check_eq("fl_count", 32'(count), 32'd0);
      next_cycle();
    end

    // Mid-operation reset: outputs hold until the edge, then return to reset state.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 2);
      din = 8'h41 + 8'(c);
      @(negedge clk);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_hold_valid", 32'(out_valid), 32'd1);
    check_eq("mr_hold_dout", 32'(dout), 32'h41);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_out_valid", 32'(out_valid), 32'd0);
    check_eq("mr_dout", 32'(dout), 32'h00);
    check_eq("mr_count", 32'(count), 32'd0);
    next_cycle();

    // Random traffic on both instances against queue scoreboards.
    sent = 0; got = 0; s_sent = 0; s_got = 0;
    for (int cyc = 0; cyc < 3000 && (got < 30 || s_got < 30); cyc++) begin
      in_valid    = (sent < 30) && ($urandom_range(0, 3) != 0);
      din         = 8'($urandom);
      out_ready   = ($urandom_range(0, 2) != 0);
      s_in_valid  = (s_sent < 30) && ($urandom_range(0, 3) != 0);
      s_din       = 1'($urandom);
      s_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check_eq("rnd_count", 32'(count), 32'(q.size()));
      check_eq("rnd_count_range", 32'(count <= 3'd4), 32'd1);
      check_eq("rnd_in_ready", 32'(in_ready), 32'((q.size() < 4) || out_ready));
      if (out_valid) begin
        check_eq("rnd_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check_eq("rnd_dout", 32'(dout), 32'(q[0]));
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(din);
        sent++;
      end
      check_eq("rnd_s_count", 32'(s_count), 32'(sq.size()));
      check_eq("rnd_s_in_ready", 32'(s_in_ready), 32'((sq.size() < 1) || s_out_ready));
      if (s_out_valid) begin
        check_eq("rnd_s_nonempty", 32'(sq.size() != 0), 32'd1);
        if (sq.size() != 0) begin
          check_eq("rnd_s_dout", 32'(s_dout), 32'(sq[0]));
          if (s_out_ready) begin
            void'(sq.pop_front());
            s_got++;
          end
        end
      end
      if (s_in_valid && s_in_ready) begin
        sq.push_back(s_din);
        s_sent++;
      end
      next_cycle();
    end
    check_eq("rnd_done", 32'(got), 32'd30);
    check_eq("rnd_s_done", 32'(s_got), 32'd30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
